// File: rtl/grant_lock_mux.sv
// Packet-locking 4:1 mux: arbitrates once per packet via an external round-robin
// arbiter, then holds ownership until the last beat or a forced beat-count limit.
module grant_lock_mux #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            src_valid,
   input  logic [4*DATA_W-1:0]   src_data,
   input  logic [3:0]            src_last,
   output logic [3:0]            src_ready,
   output logic [3:0]            arb_req,
   input  logic [3:0]            arb_gnt,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_last,
   output logic [1:0]            out_src,
   input  logic                  out_ready,
   output logic                  trunc
);

   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               trunc_q, trunc_d;

   logic [DATA_W-1:0]  slice [4];
   logic [3:0]         eligible;
   logic               cnt_hit;
   logic               xfer;

   // Unpack the flat source bus into per-source lanes.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         slice[i] = src_data[i*DATA_W +: DATA_W];
      end
   end

   assign eligible = arb_gnt & src_valid;
   assign cnt_hit  = (cnt_q == LAST_CNT);
   assign out_src  = owner_q;
   assign trunc    = trunc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      trunc_d   = 1'b0;
      arb_req   = 4'b0000;
      src_ready = 4'b0000;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      xfer      = 1'b0;

      unique case (state_q)
         IDLE: begin
            arb_req = src_valid;
            // Lowest set bit wins so a malformed multi-hot grant still picks one owner.
            if (eligible[0]) begin
               owner_d = 2'd0;
               state_d = LOCKED;
            end else if (eligible[1]) begin
               owner_d = 2'd1;
               state_d = LOCKED;
            end else if (eligible[2]) begin
               owner_d = 2'd2;
               state_d = LOCKED;
            end else if (eligible[3]) begin
               owner_d = 2'd3;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            out_valid          = src_valid[owner_q];
            out_data           = slice[owner_q];
            out_last           = src_last[owner_q] | cnt_hit;
            src_ready[owner_q] = out_ready;
            xfer               = out_valid & out_ready;
            if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (out_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  trunc_d = cnt_hit & ~src_last[owner_q];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_grant_lock_mux.sv
// Scoreboard bench for grant_lock_mux: directed packets with hand-computed beats,
// checked by an independent output monitor plus inline control-signal checks.
module tb_grant_lock_mux;

   localparam int unsigned DW = 8;

   typedef struct packed {
      logic [1:0] src;
      logic       last;
      logic [7:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    src_valid;
   logic [4*DW-1:0] src_data;
   logic [3:0]    src_last;
   logic [3:0]    src_ready;
   logic [3:0]    arb_req;
   logic [3:0]    arb_gnt;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [1:0]    out_src;
   logic          out_ready;
   logic          trunc;

   logic [3:0]    gnt_drv;
   logic          use_rr;
   logic [1:0]    rr_ptr;
   logic [3:0]    rr_gnt;
   logic [1:0]    rr_idx;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            trunc_cnt = 0;
   beat_t         exp_q[$];
   int            xfer_cyc[$];
   logic [8:0]    sq0[$], sq1[$], sq2[$], sq3[$];

   grant_lock_mux #(.DATA_W(DW), .MAX_BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
      .arb_req(arb_req), .arb_gnt(arb_gnt),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
      .out_ready(out_ready), .trunc(trunc)
   );

   always #5 clk = ~clk;

   // Reference round-robin arbiter; pointer advances only on a grant.
   always_comb begin
      rr_gnt = 4'b0000;
      rr_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (arb_req[2'(32'(rr_ptr) + k)]) begin
            rr_gnt = 4'b0000;
            rr_gnt[2'(32'(rr_ptr) + k)] = 1'b1;
            rr_idx = 2'(32'(rr_ptr) + k);
         end
      end
   end
   assign arb_gnt = use_rr ? rr_gnt : gnt_drv;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) rr_ptr <= 2'd0;
      else if (use_rr && rr_gnt != 4'b0000) rr_ptr <= rr_idx + 2'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Source models: pop on accept at the edge, then present the new head.
   initial begin
      src_valid = 4'b0;
      src_data  = '0;
      src_last  = 4'b0;
      forever begin
         @(posedge clk);
         if (src_valid[0] && src_ready[0]) void'(sq0.pop_front());
         if (src_valid[1] && src_ready[1]) void'(sq1.pop_front());
         if (src_valid[2] && src_ready[2]) void'(sq2.pop_front());
         if (src_valid[3] && src_ready[3]) void'(sq3.pop_front());
         #2;
         src_valid[0] = sq0.size() != 0;
         src_valid[1] = sq1.size() != 0;
         src_valid[2] = sq2.size() != 0;
         src_valid[3] = sq3.size() != 0;
         {src_last[0], src_data[7:0]}   = (sq0.size() != 0) ? sq0[0] : 9'h0;
         {src_last[1], src_data[15:8]}  = (sq1.size() != 0) ? sq1[0] : 9'h0;
         {src_last[2], src_data[23:16]} = (sq2.size() != 0) ? sq2[0] : 9'h0;
         {src_last[3], src_data[31:24]} = (sq3.size() != 0) ? sq3[0] : 9'h0;
      end
   end

   // Output monitor: every transferred beat is popped from the scoreboard.
   always @(negedge clk) begin
      if (trunc) trunc_cnt++;
      if (out_valid && out_ready) begin
         xfer_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {21'd0, out_src, out_last, out_data}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat", {21'd0, out_src, out_last, out_data}, {21'd0, e});
         end
      end
   end

   task automatic load(input int s, input logic [7:0] d, input logic l);
      case (s)
         0: sq0.push_back({l, d});
         1: sq1.push_back({l, d});
         2: sq2.push_back({l, d});
         default: sq3.push_back({l, d});
      endcase
   endtask

   task automatic expb(input int s, input logic [7:0] d, input logic l);
      beat_t b;
      b.src = 2'(s);
      b.last = l;
      b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic flush_src();
      sq0.delete();
      sq1.delete();
      sq2.delete();
      sq3.delete();
   endtask

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int tr0;
      int k;
      bit done;
      rst = 1'b1;
      out_ready = 1'b0;
      gnt_drv = 4'b0;
      use_rr = 1'b0;
      step();
      step();
      neg();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(src_ready), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_src", 32'(out_src), 32'd0);
      chk("rst_trunc", 32'(trunc), 32'd0);

      // Single three-beat packet from source 1.
      step();
      rst = 1'b0;
      load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0); load(1, 8'h13, 1'b1);
      expb(1, 8'h11, 1'b0); expb(1, 8'h12, 1'b0); expb(1, 8'h13, 1'b1);
      gnt_drv = 4'b0010;
      out_ready = 1'b1;
      neg();
      chk("idle_req", 32'(arb_req), 32'h2);
      chk("idle_valid", 32'(out_valid), 32'd0);
      step();
      neg();
      chk("lock_valid", 32'(out_valid), 32'd1);
      chk("lock_src", 32'(out_src), 32'd1);
      chk("lock_req", 32'(arb_req), 32'd0);
      chk("lock_ready", 32'(src_ready), 32'h2);
      wait_drain(10);
      neg();
      chk("pkt1_idle", 32'(out_valid), 32'd0);
      chk("pkt1_trunc", 32'(trunc), 32'd0);
      chk("pkt1_src_hold", 32'(out_src), 32'd1);

      // Backpressure with out_ready toggling.
      load(1, 8'h21, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h23, 1'b1);
      expb(1, 8'h21, 1'b0); expb(1, 8'h22, 1'b0); expb(1, 8'h23, 1'b1);
      step();
      k = 0;
      done = 1'b0;
      for (int it = 0; it < 20 && !done; it++) begin
         out_ready = (k % 2) == 0;
         k++;
         neg();
         if (out_valid) begin
            chk("bp_ready", 32'(src_ready), {30'd0, out_ready, 1'b0});
            chk("bp_req", 32'(arb_req), 32'd0);
            if (!out_ready && exp_q.size() != 0) chk("bp_hold", 32'(out_data), 32'(exp_q[0].data));
         end
         @(posedge clk);
         if (exp_q.size() == 0) done = 1'b1;
         #1;
      end
      if (!done) chk("bp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      out_ready = 1'b1;
      gnt_drv = 4'b0;

      // Truncation at four beats; remaining two re-arbitrate as a new packet.
      tr0 = trunc_cnt;
      load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b0); load(0, 8'h33, 1'b0);
      load(0, 8'h34, 1'b0); load(0, 8'h35, 1'b0); load(0, 8'h36, 1'b0);
      expb(0, 8'h31, 1'b0); expb(0, 8'h32, 1'b0); expb(0, 8'h33, 1'b0);
      expb(0, 8'h34, 1'b1); expb(0, 8'h35, 1'b0); expb(0, 8'h36, 1'b0);
      gnt_drv = 4'b0001;
      wait_drain(30);
      neg();
      chk("trunc_pulses", 32'(trunc_cnt - tr0), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd0);
      chk("stall_req", 32'(arb_req), 32'd0);
      chk("stall_src", 32'(out_src), 32'd0);

      // Reset mid-packet on source 3.
      step();
      rst = 1'b1;
      flush_src();
      step();
      rst = 1'b0;
      load(3, 8'h41, 1'b0); load(3, 8'h42, 1'b0); load(3, 8'h43, 1'b0);
      load(3, 8'h44, 1'b0); load(3, 8'h45, 1'b1);
      expb(3, 8'h41, 1'b0); expb(3, 8'h42, 1'b0);
      gnt_drv = 4'b1000;
      out_ready = 1'b1;
      wait_drain(10);
      rst = 1'b1;
      out_ready = 1'b0;
      step();
      neg();
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_src", 32'(out_src), 32'd0);
      chk("mrst_ready", 32'(src_ready), 32'd0);
      chk("mrst_last", 32'(out_last), 32'd0);
      chk("mrst_trunc", 32'(trunc), 32'd0);
      step();
      flush_src();
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      tr0 = trunc_cnt;
      load(3, 8'h51, 1'b0); load(3, 8'h52, 1'b0); load(3, 8'h53, 1'b0); load(3, 8'h54, 1'b1);
      expb(3, 8'h51, 1'b0); expb(3, 8'h52, 1'b0); expb(3, 8'h53, 1'b0); expb(3, 8'h54, 1'b1);
      wait_drain(20);
      neg();
      chk("post_rst_trunc", 32'(trunc_cnt - tr0), 32'd0);
      chk("post_rst_idle", 32'(out_valid), 32'd0);

      // Bad grants: no eligible source, then multi-hot grant.
      step();
      gnt_drv = 4'b1000;
      load(0, 8'h61, 1'b1);
      load(2, 8'h62, 1'b1);
      step();
      neg();
      chk("bg_req", 32'(arb_req), 32'h5);
      chk("bg_idle1", 32'(out_valid), 32'd0);
      step();
      neg();
      chk("bg_idle2", 32'(out_valid), 32'd0);
      step();
      expb(2, 8'h62, 1'b1);
      gnt_drv = 4'b0110;
      step();
      neg();
      chk("bg_owner", 32'(out_src), 32'd2);
      wait_drain(10);
      gnt_drv = 4'b0;
      expb(0, 8'h61, 1'b1);
      gnt_drv = 4'b0001;
      wait_drain(10);
      gnt_drv = 4'b0;

      // Round-robin across all sources with a real arbiter.
      use_rr = 1'b1;
      load(0, 8'h70, 1'b1); load(0, 8'h74, 1'b1);
      load(1, 8'h71, 1'b1); load(2, 8'h72, 1'b1); load(3, 8'h73, 1'b1);
      expb(0, 8'h70, 1'b1); expb(1, 8'h71, 1'b1); expb(2, 8'h72, 1'b1);
      expb(3, 8'h73, 1'b1); expb(0, 8'h74, 1'b1);
      xfer_cyc.delete();
      wait_drain(40);
      neg();
      chk("rr_count", 32'(xfer_cyc.size()), 32'd5);
      if (xfer_cyc.size() == 5) begin
         for (int i = 1; i < 5; i++) chk("rr_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
